// File: rtl/chunked_seq_adder.sv
// Multi-cycle add/subtract unit: CHUNK bits per cycle, LSB chunk first, rippled carry.
// Valid/ready handshake on both sides; carry, signed-overflow and zero flags on completion.
module chunked_seq_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             carryIn,
    input  logic             sub,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NCHUNK - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             cin_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q, ovf_q, zero_q;

    logic             accept, last_chunk;
    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             c_out, c_into_msb;
    logic [WIDTH-1:0] sum_next;

    assign accept     = (state_q == StIdle) && inValid;
    assign last_chunk = (idx_q == LastIdx);

    always_comb begin
        a_chunk  = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk  = b_q[idx_q*CHUNK +: CHUNK];
        {c_out, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, cin_q};
        // Carry into the chunk MSB recovered from the sum bit and its two operand bits.
        c_into_msb = s_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
        sum_next = sum_q;
        sum_next[idx_q*CHUNK +: CHUNK] = s_chunk;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (inValid) state_d = StRun;
            StRun:   if (last_chunk) state_d = StDone;
            StDone:  if (outReady) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Subtraction runs as A + ~B + ~borrow_in.
                a_q   <= input1;
                b_q   <= sub ? ~input2 : input2;
                cin_q <= sub ? ~carryIn : carryIn;
                idx_q <= '0;
            end else if (state_q == StRun) begin
                sum_q <= sum_next;
                cin_q <= c_out;
                idx_q <= idx_q + IDX_W'(1);
                if (last_chunk) begin
                    carry_q <= c_out;
                    ovf_q   <= c_into_msb ^ c_out;
                    zero_q  <= (sum_next == '0);
                end
            end
        end
    end

    assign inReady  = (state_q == StIdle);
    assign outValid = (state_q == StDone);
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule
